ssc_pattern_detect: RTL and testbench
=====================================

// Module: ssc_pattern_detect
// PURPOSE
//  Parametrised serial sequence checker; successor to the fixed 4-bit SSC checker.
//  Shifts a serial bit stream (qualified by data_valid) into a PAT_W-bit history.
//  Compares the history against a runtime-loadable pattern and flags matches.
//  Supports overlap / non-overlap modes and keeps a saturating match counter.
//  Sits between the board input synchroniser and the LED/seven-seg display logic.
// PARAMETERS
//  PAT_W        4        pattern/history width in bits, 2..32
//  CNT_W        8        match counter width
//  DEFAULT_PAT  4'b1101  pattern loaded at reset, PAT_W bits wide
// PORTS
//  clk_main       in   1      system clock, rising edge
//  rst_n          in   1      asynchronous reset, active-low
//  data_in        in   1      serial data bit
//  data_valid     in   1      data_in is sampled on this edge when 1
//  pat_load       in   1      load pat_in as the new pattern, restart detection
//  pat_in         in   PAT_W  new pattern value
//  overlap_en     in   1      1 = overlapping matches, 0 = non-overlapping
//  clr            in   1      clear match_cnt
//  out_light      out  PAT_W  current history; newest bit at LSB
//  success_light  out  1      match flag (see BEHAVIOUR / CONFIGURATION)
//  match_cnt      out  CNT_W  number of matches, saturating
//  armed          out  1      1 when in RUN, i.e. history holds PAT_W valid bits
// BEHAVIOUR
//  Reset (async, rst_n=0) values:
//   - out_light=0, success_light=0, match_cnt=0, armed=0
//   - pat_reg=DEFAULT_PAT, fill_cnt=0, state=FILL
//  Shift: on an edge with data_valid=1, hist <= {hist[PAT_W-2:0], data_in}.
//  FSM:
//   - FILL: fill_cnt counts valid bits.
//   - FILL->RUN on the edge where the PAT_W-th bit arrives (fill_cnt==PAT_W-1 && data_valid).
//   - RUN: stays in RUN; armed=1.
//  Match evaluation:
//   - Evaluated on the edge where the PAT_W-th valid bit or any later valid bit arrives.
//   - Condition: {hist[PAT_W-2:0],data_in}==pat_reg.
//   - success_light is registered: high in the cycle after that edge (latency 1).
//   - Pulse width: exactly 1 cycle per matching bit.
//   - data_valid=0: no shift, no match, success_light=0 next cycle.
//  Overlap mode (overlap_en=1): stay in RUN after a match; the next bit can match again.
//  Non-overlap mode (overlap_en=0), on a match:
//   - state returns to FILL, fill_cnt=0, and out_light is cleared to 0.
//   - The next match needs PAT_W fresh bits.
//   - overlap_en is sampled per edge; changing it mid-stream affects only future matches.
//  pat_load=1 (synchronous):
//   - pat_reg<=pat_in, hist<=0, fill_cnt<=0, state<=FILL, success_light<=0.
//   - Any same-cycle data bit is dropped (pat_load has priority).
//   - match_cnt is kept.
//  match_cnt: +1 per match; saturates at 2^CNT_W-1 with no wrap.
//  clr=1: match_cnt<=0; clr wins over a same-cycle match, but the success_light pulse still fires.
//  Reset mid-stream: all state is lost immediately and returns to the reset values above.
// CONFIGURATION
//  Macro SSC_MATCH_LATCH_EN:
//   - Defined: success_light is sticky. It sets on the first match and holds until
//     clr=1, pat_load=1, or reset. Set and clear on the same edge -> clear wins.
//   - Undefined: success_light is the 1-cycle pulse described above.
//   - match_cnt behaviour is identical in both builds.
// TESTING
//  T1: reset release, DEFAULT_PAT=1101, overlap_en=1, bits 1,1,0,1
//      -> success_light pulse 1 cycle after 4th bit; match_cnt=1; out_light=1101.
//  T2: overlap_en=1, stream 1,1,0,1,1,0,1 -> pulses after bits 4 and 7; match_cnt=2.
//  T3: overlap_en=0, same stream -> pulse after bit 4 only; match_cnt=1;
//      armed=0 after the match; out_light=0101 at end.
//  T4: pat_load with pat_in=0110 while a valid bit 1 arrives the same cycle
//      -> bit dropped, out_light=0, armed=0; stream 0,1,1,0 -> one pulse.
//  T5: CNT_W=2, 5 matches -> match_cnt sticks at 3; clr coincident with a match -> match_cnt=0.
//  T6: SSC_MATCH_LATCH_EN build -> success_light stays 1 after T1 until clr;
//      rst_n pulsed mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ssc_pattern_detect.sv
`default_nettype none
// ============================================================================
// Module      : ssc_pattern_detect
// Description : Parametrised serial sequence checker. Valid serial bits are
//               shifted into a PAT_W-bit history which is compared against a
//               runtime-loadable pattern. Supports overlapping and
//               non-overlapping detection and keeps a saturating match count.
// Macro       : SSC_MATCH_LATCH_EN - when defined, success_light is sticky
//               (set on a match, cleared by clr / pat_load / reset);
//               otherwise it is a 1-cycle pulse per match.
// Ports       : clk_main      - system clock, rising edge
//               rst_n         - asynchronous reset, active-low
//               data_in       - serial data bit
//               data_valid    - data_in is sampled on this edge when 1
//               pat_load      - load pat_in as pattern, restart detection
//               pat_in        - new pattern value
//               overlap_en    - 1 = overlapping, 0 = non-overlapping matches
//               clr           - clear match_cnt
//               out_light     - current history, newest bit at LSB
//               success_light - match flag (pulse or sticky)
//               match_cnt     - saturating match counter
//               armed         - history holds PAT_W valid bits
// Revision    : 1.0 - initial release
// ============================================================================
module ssc_pattern_detect #(
    parameter int               PAT_W       = 4,
    parameter int               CNT_W       = 8,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(4'b1101)
) (
    input  logic             clk_main,
    input  logic             rst_n,
    input  logic             data_in,
    input  logic             data_valid,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             overlap_en,
    input  logic             clr,
    output logic [PAT_W-1:0] out_light,
    output logic             success_light,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);

    localparam int                c_FC_W      = $clog2(PAT_W);
    localparam logic [c_FC_W-1:0] c_FILL_LAST = c_FC_W'(PAT_W - 1);

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_FC_W-1:0]  r_fill_cnt;
    logic [c_FC_W-1:0]  w_fill_nxt;
    logic [PAT_W-1:0]   r_hist;
    logic [PAT_W-1:0]   w_hist_nxt;
    logic [PAT_W-1:0]   w_shift;
    logic [PAT_W-1:0]   r_pat;
    logic [CNT_W-1:0]   r_match_cnt;
    logic               r_success;
    logic               w_full;
    logic               w_match;

    // History as it will look once the incoming bit is shifted in; matching
    // is done on this value so the flag can be registered with latency 1.
    assign w_shift = {r_hist[PAT_W-2:0], data_in};

    // The incoming bit completes a full window either in RUN or when it is
    // the PAT_W-th bit collected in FILL.
    assign w_full = (r_state == S_RUN) || (r_fill_cnt == c_FILL_LAST);

    // State register
    always_ff @(posedge clk_main or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, history and match decode
    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill_cnt;
        w_hist_nxt  = r_hist;
        w_match     = 1'b0;
        if (pat_load) begin
            // Restart detection; a same-cycle data bit is deliberately dropped.
            w_state_nxt = S_FILL;
            w_fill_nxt  = '0;
            w_hist_nxt  = '0;
        end else if (data_valid) begin
            w_hist_nxt = w_shift;
            w_match    = w_full && (w_shift == r_pat);
            if (r_state == S_FILL) begin
                if (r_fill_cnt == c_FILL_LAST) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_fill_nxt = r_fill_cnt + 1'b1;
                end
            end
            // Non-overlap: consumed bits may not contribute to the next match.
            if (w_match && !overlap_en) begin
                w_state_nxt = S_FILL;
                w_fill_nxt  = '0;
                w_hist_nxt  = '0;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk_main or negedge rst_n) begin
        if (!rst_n) begin
            r_fill_cnt  <= '0;
            r_hist      <= '0;
            r_pat       <= DEFAULT_PAT;
            r_match_cnt <= '0;
            r_success   <= 1'b0;
        end else begin
            r_fill_cnt <= w_fill_nxt;
            r_hist     <= w_hist_nxt;
            if (pat_load) begin
                r_pat <= pat_in;
            end
            // clr has priority over a coincident match; counter never wraps.
            if (clr) begin
                r_match_cnt <= '0;
            end else if (w_match && (r_match_cnt != {CNT_W{1'b1}})) begin
                r_match_cnt <= r_match_cnt + 1'b1;
            end
`ifdef SSC_MATCH_LATCH_EN
            if (clr || pat_load) begin
                r_success <= 1'b0;
            end else if (w_match) begin
                r_success <= 1'b1;
            end
`else
            r_success <= w_match;
`endif
        end
    end

    assign out_light     = r_hist;
    assign success_light = r_success;
    assign match_cnt     = r_match_cnt;
    assign armed         = (r_state == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_ssc_pattern_detect.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssc_pattern_detect
// Description : Self-checking bench for ssc_pattern_detect. Two instances
//               (CNT_W=8 and CNT_W=2) share the same stimulus. Directed
//               table vectors, hand-written corner sequences and random
//               stimulus are compared against a behavioural model that keeps
//               the valid bits received since the last restart in a queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssc_pattern_detect;

    localparam int PW = 4;

    logic          clk_main   = 1'b0;
    logic          rst_n      = 1'b0;
    logic          data_in    = 1'b0;
    logic          data_valid = 1'b0;
    logic          pat_load   = 1'b0;
    logic [PW-1:0] pat_in     = '0;
    logic          overlap_en = 1'b1;
    logic          clr        = 1'b0;

    logic [PW-1:0] light_a, light_b;
    logic          succ_a, succ_b, armed_a, armed_b;
    logic [7:0]    cnt_a;
    logic [1:0]    cnt_b;

    always #5 clk_main = ~clk_main;

    ssc_pattern_detect #(.PAT_W(PW), .CNT_W(8), .DEFAULT_PAT(4'b1101)) u_dut_a (
        .clk_main(clk_main), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
        .pat_load(pat_load), .pat_in(pat_in), .overlap_en(overlap_en), .clr(clr),
        .out_light(light_a), .success_light(succ_a), .match_cnt(cnt_a), .armed(armed_a)
    );

    ssc_pattern_detect #(.PAT_W(PW), .CNT_W(2), .DEFAULT_PAT(4'b1101)) u_dut_b (
        .clk_main(clk_main), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
        .pat_load(pat_load), .pat_in(pat_in), .overlap_en(overlap_en), .clr(clr),
        .out_light(light_b), .success_light(succ_b), .match_cnt(cnt_b), .armed(armed_b)
    );

    // ---------------- behavioural reference model ----------------
    bit            m_q[$];     // valid bits since last restart, newest at back (max PW kept)
    int            m_fresh;    // number of valid bits since last restart
    logic [PW-1:0] m_pat;
    int            m_cnt_a, m_cnt_b;
    bit            m_succ;

    int checks = 0;
    int errors = 0;

    function automatic void model_reset();
        m_q.delete();
        m_fresh = 0;
        m_pat   = 4'b1101;
        m_cnt_a = 0;
        m_cnt_b = 0;
        m_succ  = 1'b0;
    endfunction

    function automatic int model_light();
        int v = 0;
        foreach (m_q[i]) v = v * 2 + int'(m_q[i]);
        return v;
    endfunction

    function automatic void model_edge();
        bit match = 1'b0;
        if (pat_load) begin
            m_pat   = pat_in;
            m_q.delete();
            m_fresh = 0;
        end else if (data_valid) begin
            m_q.push_back(data_in);
            if (m_q.size() > PW) void'(m_q.pop_front());
            m_fresh++;
            match = (m_fresh >= PW) && (model_light() == int'(m_pat));
            if (match && !overlap_en) begin
                m_q.delete();
                m_fresh = 0;
            end
        end
        if (clr) begin
            m_cnt_a = 0;
            m_cnt_b = 0;
        end else if (match) begin
            m_cnt_a = (m_cnt_a < 255) ? m_cnt_a + 1 : 255;
            m_cnt_b = (m_cnt_b < 3)   ? m_cnt_b + 1 : 3;
        end
`ifdef SSC_MATCH_LATCH_EN
        if (clr || pat_load) m_succ = 1'b0;
        else if (match)      m_succ = 1'b1;
`else
        m_succ = match;
`endif
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_model();
        bit armed_m = (m_fresh >= PW);
        chk("light_a", 32'(light_a), 32'(model_light()));
        chk("succ_a",  32'(succ_a),  32'(m_succ));
        chk("cnt_a",   32'(cnt_a),   32'(m_cnt_a));
        chk("armed_a", 32'(armed_a), 32'(armed_m));
        chk("light_b", 32'(light_b), 32'(model_light()));
        chk("succ_b",  32'(succ_b),  32'(m_succ));
        chk("cnt_b",   32'(cnt_b),   32'(m_cnt_b));
        chk("armed_b", 32'(armed_b), 32'(armed_m));
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare.
    task automatic step(input logic d, input logic v, input logic pl,
                        input logic [PW-1:0] pi, input logic ov, input logic c);
        data_in    = d;
        data_valid = v;
        pat_load   = pl;
        pat_in     = pi;
        overlap_en = ov;
        clr        = c;
        @(posedge clk_main);
        model_edge();
        #1;
        check_model();
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic          d, v, pl;
        logic [PW-1:0] pi;
        logic          ov, c;
        logic [PW-1:0] e_light;
        logic          e_succ;     // pulse build
        logic          e_succ_l;   // sticky build
        logic [7:0]    e_cnt;
        logic          e_armed;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // T1/T2: overlap, stream 1101101
        tbl.push_back('{1,1,0,4'h0,1,0, 4'b0001,0,0,8'd0,0});
        tbl.push_back('{1,1,0,4'h0,1,0, 4'b0011,0,0,8'd0,0});
        tbl.push_back('{0,1,0,4'h0,1,0, 4'b0110,0,0,8'd0,0});
        tbl.push_back('{1,1,0,4'h0,1,0, 4'b1101,1,1,8'd1,1});
        tbl.push_back('{1,1,0,4'h0,1,0, 4'b1011,0,1,8'd1,1});
        tbl.push_back('{0,1,0,4'h0,1,0, 4'b0110,0,1,8'd1,1});
        tbl.push_back('{1,1,0,4'h0,1,0, 4'b1101,1,1,8'd2,1});
        tbl.push_back('{1,0,0,4'h0,1,0, 4'b1101,0,1,8'd2,1});  // idle bit ignored
        tbl.push_back('{0,0,0,4'h0,1,1, 4'b1101,0,0,8'd0,1});  // clr
        tbl.push_back('{0,0,1,4'hD,0,0, 4'b0000,0,0,8'd0,0});  // restart
        // T3: non-overlap, stream 1101101
        tbl.push_back('{1,1,0,4'h0,0,0, 4'b0001,0,0,8'd0,0});
        tbl.push_back('{1,1,0,4'h0,0,0, 4'b0011,0,0,8'd0,0});
        tbl.push_back('{0,1,0,4'h0,0,0, 4'b0110,0,0,8'd0,0});
        tbl.push_back('{1,1,0,4'h0,0,0, 4'b0000,1,1,8'd1,0});
        tbl.push_back('{1,1,0,4'h0,0,0, 4'b0001,0,1,8'd1,0});
        tbl.push_back('{0,1,0,4'h0,0,0, 4'b0010,0,1,8'd1,0});
        tbl.push_back('{1,1,0,4'h0,0,0, 4'b0101,0,1,8'd1,0});
        // T4: pat_load with coincident valid bit, then 0110
        tbl.push_back('{1,1,1,4'h6,1,0, 4'b0000,0,0,8'd1,0});
        tbl.push_back('{0,1,0,4'h0,1,0, 4'b0000,0,0,8'd1,0});
        tbl.push_back('{1,1,0,4'h0,1,0, 4'b0001,0,0,8'd1,0});
        tbl.push_back('{1,1,0,4'h0,1,0, 4'b0011,0,0,8'd1,0});
        tbl.push_back('{0,1,0,4'h0,1,0, 4'b0110,1,1,8'd2,1});

        // ---------------- reset ----------------
        model_reset();
        repeat (3) @(posedge clk_main);
        #1;
        check_model();
        chk("rst_light", 32'(light_a), 32'd0);
        chk("rst_armed", 32'(armed_a), 32'd0);
        rst_n = 1'b1;

        // ---------------- table ----------------
        foreach (tbl[i]) begin
            step(tbl[i].d, tbl[i].v, tbl[i].pl, tbl[i].pi, tbl[i].ov, tbl[i].c);
            chk($sformatf("tbl%0d_light", i), 32'(light_a), 32'(tbl[i].e_light));
`ifdef SSC_MATCH_LATCH_EN
            chk($sformatf("tbl%0d_succ", i),  32'(succ_a),  32'(tbl[i].e_succ_l));
`else
            chk($sformatf("tbl%0d_succ", i),  32'(succ_a),  32'(tbl[i].e_succ));
`endif
            chk($sformatf("tbl%0d_cnt", i),   32'(cnt_a),   32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_armed", i), 32'(armed_a), 32'(tbl[i].e_armed));
        end

        // ---------------- T5: saturation, clr vs match ----------------
        // History is 0110 with pattern 0110; each further 1,1,0 matches again.
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 0, 4'h0, 1, 0);
            step(1, 1, 0, 4'h0, 1, 0);
            step(0, 1, 0, 4'h0, 1, 0);
        end
        chk("sat_cnt_b", 32'(cnt_b), 32'd3);
        chk("sat_cnt_a", 32'(cnt_a), 32'd5);
        step(1, 1, 0, 4'h0, 1, 0);
        step(1, 1, 0, 4'h0, 1, 0);
        step(0, 1, 0, 4'h0, 1, 1);
        chk("clr_match_cnt_a", 32'(cnt_a), 32'd0);
        chk("clr_match_cnt_b", 32'(cnt_b), 32'd0);
`ifdef SSC_MATCH_LATCH_EN
        chk("clr_match_succ", 32'(succ_a), 32'd0);
`else
        chk("clr_match_succ", 32'(succ_a), 32'd1);
`endif

        // ---------------- T6: asynchronous reset mid-stream ----------------
        step(1, 1, 0, 4'h0, 1, 0);
        step(1, 1, 0, 4'h0, 1, 0);
        data_valid = 1'b0;
        pat_load   = 1'b0;
        clr        = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_light", 32'(light_a), 32'd0);
        chk("arst_succ",  32'(succ_a),  32'd0);
        chk("arst_cnt",   32'(cnt_a),   32'd0);
        chk("arst_armed", 32'(armed_a), 32'd0);
        @(posedge clk_main);
        #1 rst_n = 1'b1;
        check_model();
        // Default pattern restored by reset
        step(1, 1, 0, 4'h0, 1, 0);
        step(1, 1, 0, 4'h0, 1, 0);
        step(0, 1, 0, 4'h0, 1, 0);
        step(1, 1, 0, 4'h0, 1, 0);
        chk("post_rst_match", 32'(succ_a), 32'd1);

        // ---------------- random stimulus ----------------
        begin
            logic ov_r = 1'b1;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 49) == 0) ov_r = ~ov_r;
                step(1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 39) == 0),
                     4'($urandom_range(0, 15)),
                     ov_r,
                     ($urandom_range(0, 29) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
